// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and helpers for the character-LCD write engine.
//   lcd_state_t      - engine FSM states
//   LCD_CMD_CLEAR/HOME - instructions that need the long execution wait
//   lcd_is_long_wait - decides the post-transfer wait class of a byte
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        WAIT,
        DONE
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) are
    // the only slow instructions; data writes never are.
    function automatic logic lcd_is_long_wait(input logic rs, input logic [7:0] b);
        return !rs && ((b == LCD_CMD_CLEAR) || ({b[7:1], 1'b0} == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: small synchronous FIFO holding {RS,DATA} entries ahead of
// the LCD engine. Push and pop in the same cycle are both honoured.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_push/i_din   - write side (ignored when full)
//   i_pop          - read side, o_dout shows the head (ignored when empty)
//   o_empty/o_full - occupancy flags
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("lcd_cmd_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit separates full from empty.
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_dout  = r_mem[r_rd[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: write-only HD44780-class LCD bus engine. Accepts
// command/data bytes over valid/ready, generates setup / EN pulse / hold
// timing in 8-bit or 4-bit (high nibble first) mode, then waits the
// instruction execution time (long for clear/home) before pulsing oDone.
// Optional: define LCD_CMD_FIFO_EN to put a FIFO_DEPTH-entry command FIFO
// in front of the engine (oReady = !full).
// Ports:
//   iCLK, iRST (async, active-high)
//   iDATA/iRS/iValid/oReady - byte input handshake
//   oDone  - one-cycle pulse when a byte (including its wait) completes
//   oBusy  - engine active (or FIFO non-empty)
//   LCD_DATA/LCD_EN/LCD_RW/LCD_RS - LCD pins (RW tied low)
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int INTERFACE_BITS = 8,
    parameter int SETUP_CYC      = 2,
    parameter int EN_CYC         = 16,
    parameter int HOLD_CYC       = 2,
    parameter int SHORT_WAIT_CYC = 2500,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic       LCD_RS
);

    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC > MAX_A) ? HOLD_CYC : MAX_A;
    localparam int MAX_C   = (SHORT_WAIT_CYC > MAX_B) ? SHORT_WAIT_CYC : MAX_B;
    localparam int MAX_CYC = (LONG_WAIT_CYC > MAX_C) ? LONG_WAIT_CYC : MAX_C;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam bit NIBBLE  = (INTERFACE_BITS == 4);

    if (INTERFACE_BITS != 8 && INTERFACE_BITS != 4) begin : g_bad_bus
        $error("lcd_write_engine: INTERFACE_BITS must be 8 or 4");
    end
    if (SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 ||
        SHORT_WAIT_CYC < 1 || LONG_WAIT_CYC < 1) begin : g_bad_cyc
        $error("lcd_write_engine: all cycle parameters must be >= 1");
    end

    // Counter holds "remaining cycles - 1" of the current state.
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_SHORT = CW'(SHORT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(LONG_WAIT_CYC - 1);

    lcd_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_lo_nib;
    logic          r_long;
    logic          r_nib_hi;
    logic [7:0]    r_lcd_data;
    logic          r_lcd_rs;
    logic          r_lcd_en;
    logic          r_done;

    logic          w_src_valid;
    logic          w_src_rs;
    logic [7:0]    w_src_data;
    logic          w_take;
    logic          w_nib_next;

    assign w_take = (r_state == IDLE) && w_src_valid;

`ifdef LCD_CMD_FIFO_EN
    logic       w_full;
    logic       w_empty;
    logic [8:0] w_head;

    // No bypass: a pushed byte is popped by the engine one cycle later at best.
    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_push  (iValid && !w_full),
        .i_din   ({iRS, iDATA}),
        .i_pop   (w_take),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_src_valid = !w_empty;
    assign w_src_rs    = w_head[8];
    assign w_src_data  = w_head[7:0];
    assign oReady      = !w_full;
    assign oBusy       = (r_state != IDLE) || !w_empty;
`else
    logic w_unused_depth;

    assign w_unused_depth = ^FIFO_DEPTH;
    assign w_src_valid    = iValid;
    assign w_src_rs       = iRS;
    assign w_src_data     = iDATA;
    assign oReady         = (r_state == IDLE);
    assign oBusy          = (r_state != IDLE);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        w_nib_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_src_valid) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = LD_SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ENABLE;
                    w_cnt_nxt   = LD_EN;
                end
            end
            ENABLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = LD_HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    if (r_nib_hi) begin
                        // High nibble sent; go round again with the low one.
                        w_state_nxt = SETUP;
                        w_cnt_nxt   = LD_SETUP;
                        w_nib_next  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = r_long ? LD_LONG : LD_SHORT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_lo_nib   <= '0;
            r_long     <= 1'b0;
            r_nib_hi   <= 1'b0;
            r_lcd_data <= '0;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            // Pin outputs follow the next state so they line up with it.
            r_lcd_en <= (w_state_nxt == ENABLE);
            r_done   <= (w_state_nxt == DONE);
            if (w_take) begin
                r_lo_nib   <= w_src_data[3:0];
                r_long     <= lcd_is_long_wait(w_src_rs, w_src_data);
                r_nib_hi   <= NIBBLE;
                r_lcd_rs   <= w_src_rs;
                r_lcd_data <= NIBBLE ? {w_src_data[7:4], 4'h0} : w_src_data;
            end else if (w_nib_next) begin
                r_nib_hi   <= 1'b0;
                r_lcd_data <= {r_lo_nib, 4'h0};
            end
        end
    end

    assign oDone    = r_done;
    assign LCD_DATA = r_lcd_data;
    assign LCD_RS   = r_lcd_rs;
    assign LCD_EN   = r_lcd_en;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: runs an 8-bit and a 4-bit engine side by side with
// short timing parameters. Each lane's driver pushes expected EN pulses
// and oDone cycles into queues from a transfer-level model; a monitor
// pops and compares whenever the DUT shows an EN pulse or oDone.
module tb_lcd_write_engine;

    localparam int S  = 2;
    localparam int E  = 4;
    localparam int H  = 2;
    localparam int SW = 5;
    localparam int LW = 20;
`ifdef LCD_CMD_FIFO_EN
    localparam int F = 1;
`else
    localparam int F = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int nfin  = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL lane%0d %s: got %0h expected %0h (cyc %0d)", k, nm, act, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int IB = (k == 0) ? 8 : 4;
        localparam int NP = (IB == 4) ? 2 : 1;

        logic       rst, vld, rs_i;
        logic [7:0] d_i;
        logic       rdy, done, busy, en, rw, rs_o;
        logic [7:0] d_o;

        lcd_write_engine #(
            .INTERFACE_BITS (IB),
            .SETUP_CYC      (S),
            .EN_CYC         (E),
            .HOLD_CYC       (H),
            .SHORT_WAIT_CYC (SW),
            .LONG_WAIT_CYC  (LW),
            .FIFO_DEPTH     (4)
        ) u_dut (
            .iCLK     (clk),
            .iRST     (rst),
            .iDATA    (d_i),
            .iRS      (rs_i),
            .iValid   (vld),
            .oReady   (rdy),
            .oDone    (done),
            .oBusy    (busy),
            .LCD_DATA (d_o),
            .LCD_EN   (en),
            .LCD_RW   (rw),
            .LCD_RS   (rs_o)
        );

        int         q_acc[$];
        int         q_done[$];
        int         p_rise[$];
        logic [8:0] p_val[$];
        int         last_done = -100;

        // Transfer-level model: a byte starts when both it has arrived and
        // the engine has had its idle cycle after the previous completion.
        function automatic void model(input int a, input logic r, input logic [7:0] b);
            int w, st, len;
            w   = (!r && b >= 1 && b <= 3) ? LW : SW;
            st  = (a + F > last_done + 2) ? a + F : last_done + 2;
            len = NP * (S + E + H) + w + 1;
            q_acc.push_back(a);
            q_done.push_back(st + len - 1);
            last_done = st + len - 1;
            for (int j = 0; j < NP; j++) begin
                p_rise.push_back(st + S + j * (S + E + H));
                if (IB == 8)     p_val.push_back({r, b});
                else if (j == 0) p_val.push_back({r, b[7:4], 4'h0});
                else             p_val.push_back({r, b[3:0], 4'h0});
            end
        endfunction

        // Called at a negedge; returns at the negedge after the accept edge
        // with iValid still asserted.
        task automatic send(input logic r, input logic [7:0] b, output int a);
            int n;
            n    = 0;
            vld  = 1'b1;
            rs_i = r;
            d_i  = b;
            while (!rdy && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!rdy) begin
                chk("accept_timeout", k, 0, 1);
                vld = 1'b0;
                a   = -1;
            end else begin
                a = cyc + 1;
                model(a, r, b);
                @(negedge clk);
            end
        endtask

        task automatic idle(input int n);
            vld = 1'b0;
            repeat (n) @(negedge clk);
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (q_done.size() > 0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("drain_left", k, q_done.size(), 0);
        endtask

        // Monitor
        logic       prev_en;
        logic [8:0] prev_bus;
        int         rise_c, chg_c;
        initial begin
            prev_en  = 1'b0;
            prev_bus = '0;
            rise_c   = 0;
            chg_c    = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_en  = 1'b0;
                    prev_bus = {rs_o, d_o};
                    chg_c    = cyc;
                end else begin
                    if ({rs_o, d_o} !== prev_bus) begin
                        prev_bus = {rs_o, d_o};
                        chg_c    = cyc;
                    end
                    chk("busy", k, busy, (q_acc.size() > 0 && q_acc[0] <= cyc));
                    if (en && !prev_en) begin
                        rise_c = cyc;
                        if (p_rise.size() == 0) chk("en_unexpected", k, 1, 0);
                        else begin
                            chk("en_rise_cyc", k, cyc, p_rise.pop_front());
                            chk("en_bus", k, {rs_o, d_o, rw}, {p_val.pop_front(), 1'b0});
                            chk("setup_stable", k, (cyc - chg_c >= S), 1);
                        end
                    end
                    if (!en && prev_en) chk("en_len", k, cyc - rise_c, E);
                    if (done) begin
                        if (q_done.size() == 0) chk("done_unexpected", k, 1, 0);
                        else begin
                            chk("done_cyc", k, cyc, q_done.pop_front());
                            void'(q_acc.pop_front());
                        end
                    end
                    prev_en = en;
                end
            end
        end

        // Stimulus
        initial begin
            int         a, a1, a2, d1, nacc;
            logic       r0;
            logic [7:0] b;
            rst  = 1'b1;
            vld  = 1'b0;
            rs_i = 1'b0;
            d_i  = '0;
            @(negedge clk);
            chk("rst_outputs", k, {en, d_o, rs_o, rw, done, busy}, 0);
            @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            chk("rdy_after_rst", k, rdy, 1);

            // Directed bytes: data, clear, data 0x01, home variant, plain cmd
            send(1'b1, 8'h41, a); idle(1);
            send(1'b0, 8'h01, a); idle(0);
            send(1'b1, 8'h01, a); idle(2);
            send(1'b0, 8'h03, a); idle(1);
            send(1'b0, 8'h80, a); idle(1);
            drain();

            // Held iValid, back-to-back bytes
            @(negedge clk);
            send(1'b0, 8'h30, a1);
            d1 = last_done;
            send(1'b0, 8'h38, a2);
            idle(1);
`ifndef LCD_CMD_FIFO_EN
            chk("b2b_second_accept", k, a2, d1 + 2);
`endif
            drain();

            // Reset in the middle of the EN pulse
            @(negedge clk);
            send(1'b1, 8'h55, a);
            idle(0);
            while (cyc < a + 3) @(negedge clk);
            chk("en_before_rst", k, en, 1);
            #2 rst = 1'b1;
            #1 chk("rst_mid_xfer", k, {en, done, busy}, 0);
            q_acc.delete(); q_done.delete(); p_rise.delete(); p_val.delete();
            last_done = -100;
            @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            chk("rdy_after_mid_rst", k, rdy, 1);

`ifdef LCD_CMD_FIFO_EN
            // Burst into the FIFO: fifth push fills it
            nacc = 0;
            for (int i = 0; i < 6; i++) begin
                vld  = 1'b1;
                rs_i = 1'b1;
                d_i  = 8'hA0 + 8'(i);
                if (i == 5) chk("fifo_full_rdy", k, rdy, 0);
                if (rdy) begin
                    model(cyc + 1, 1'b1, d_i);
                    nacc++;
                end
                @(negedge clk);
            end
            vld = 1'b0;
            chk("fifo_accepts", k, nacc, 5);
            drain();
`else
            nacc = 0;
`endif

            // Random traffic, biased towards the clear/home range
            for (int t = 0; t < 30; t++) begin
                r0 = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(0, 4));
                else                           b = 8'($urandom);
                send(r0, b, a);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
            end
            idle(1);
            drain();
            chk("pulses_left", k, p_rise.size(), 0);
            repeat (2) @(negedge clk);
            chk("idle_busy", k, busy, 0);
            nfin++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (nfin < 2 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (nfin < 2) chk("tb_timeout", 0, nfin, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- Parametrised write-only HD44780-class character LCD bus engine. Successor to the single-strobe LCD write controller.
- Takes command/data bytes over a valid/ready handshake and generates setup, enable-pulse and hold timing.
- Supports 8-bit or 4-bit (nibble) bus mode.
- Inserts a per-command execution wait: long for clear/home, short otherwise. No host-side delay loops needed.
- Sits between the LCD init/text sequencer and the board LCD pins.

Parameters:
- INTERFACE_BITS, 8, bus mode; 8 or 4. Any other value is an elaboration $error.
- SETUP_CYC, 2, cycles RS/DATA stable before EN rises (>=1).
- EN_CYC, 16, cycles EN held high (>=1).
- HOLD_CYC, 2, cycles RS/DATA held after EN falls (>=1).
- SHORT_WAIT_CYC, 2500, post-transfer wait for ordinary commands and data (50 us at 50 MHz).
- LONG_WAIT_CYC, 82000, post-transfer wait for clear/home (1.64 ms at 50 MHz).
- FIFO_DEPTH, 4, command FIFO entries, power of 2. Used only with LCD_CMD_FIFO_EN.

Ports:
- iCLK, in, 1, system clock.
- iRST, in, 1, reset; asynchronous, active-high.
- iDATA, in, 8, command or data byte.
- iRS, in, 1, 0 = instruction, 1 = data.
- iValid, in, 1, byte valid.
- oReady, out, 1, engine/FIFO can accept.
- oDone, out, 1, one-cycle pulse per completed byte, including its execution wait.
- oBusy, out, 1, engine active or FIFO non-empty.
- LCD_DATA, out, 8, LCD data bus.
- LCD_EN, out, 1, enable strobe.
- LCD_RW, out, 1, tied 0 (write only).
- LCD_RS, out, 1, register select.

Behaviour:
- Reset values (async, immediate on iRST): LCD_EN=0, LCD_DATA=0, LCD_RS=0, LCD_RW=0, oDone=0, oBusy=0, FIFO emptied, state IDLE. oReady=1 after reset.
- Reset mid-transfer: EN drops at once; no oDone; the partial byte is discarded.
- Accept: a byte is taken on a rising edge with iValid && oReady. iDATA/iRS are latched.
- Without FIFO, oReady = (state==IDLE). While not ready, the host holds iValid/iDATA/iRS; nothing is lost or duplicated.
- FSM: IDLE -> SETUP(SETUP_CYC) -> ENABLE(EN_CYC, LCD_EN=1) -> HOLD(HOLD_CYC) -> [4-bit, first nibble: back to SETUP with low nibble] -> WAIT(W) -> DONE(1 cycle, oDone=1) -> IDLE.
- LCD_RS and LCD_DATA are registered and driven from the latched byte during SETUP through HOLD. They keep their last value in WAIT/DONE/IDLE.
- 4-bit mode: high nibble first, on LCD_DATA[7:4]; LCD_DATA[3:0]=0.
- Wait selection: W=LONG_WAIT_CYC if latched RS=0 and byte[7:2]==0 and byte[1:0]!=0 (0x01 clear, 0x02/0x03 home). Otherwise W=SHORT_WAIT_CYC.
- Latency from accept edge to oDone cycle: 8-bit S+E+H+W+1; 4-bit 2(S+E+H)+W+1.
- Single down-counter, width $clog2(max(all cycle params)+1), reloaded on each state entry.
- oBusy=1 in every state except IDLE.

Optional Feature:
- Macro: LCD_CMD_FIFO_EN.
- Defined: a FIFO_DEPTH-entry {RS,DATA} FIFO sits in front of the engine.
  - oReady = !full.
  - The engine pops when IDLE and the FIFO is non-empty, adding 1 cycle of latency (no bypass).
  - Push and pop in the same cycle are both honoured.
  - Push when full cannot occur (oReady=0).
  - oBusy = !IDLE || !empty.
- Undefined: no FIFO, FIFO_DEPTH ignored, oReady = IDLE.

Decomposition:
- Package lcd_pkg:
  - state enum (IDLE, SETUP, ENABLE, HOLD, WAIT, DONE)
  - LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02
  - long-wait detect function
- Sub-module lcd_cmd_fifo: synchronous FIFO, async active-high reset, instantiated only under LCD_CMD_FIFO_EN.

Test Plan (S=2, E=4, H=2, SHORT=5, LONG=20, accept edge = t0):
- 8-bit, RS=1, 0x41 -> LCD_DATA=0x41, RS=1 from t1; EN=1 in cycles t3..t6; oDone in cycle t14 only; oReady=1 at t15.
- 8-bit, RS=0, 0x01 -> long wait, oDone at t29. RS=1, 0x01 (data) -> short wait, oDone at t14.
- 4-bit, RS=1, 0x41 -> first EN pulse with LCD_DATA[7:4]=4, second with 1, [3:0]=0; oDone at t22.
- iValid held with 0x30, 0x38 back-to-back -> second accepted only after oDone of the first; exactly two transfers, two oDone pulses.
- iRST asserted during ENABLE (t4) -> LCD_EN=0 immediately, no oDone, oReady=1 after release; the next byte completes normally.
- LCD_CMD_FIFO_EN, depth 4, iValid high for 6 cycles with 0xA0..0xA5 -> 0xA0..0xA4 accepted, oReady=0 at the 6th, 5 transfers in order, 5 oDone pulses, oBusy falls after the last.
